// File: rtl/serial_subtractor_nbit.sv
// Bit-serial N-bit subtractor: diff = a - b - b_in, one bit per clock, LSB first.
// Optional SERIAL_SUB_SIGNED_OVF_EN adds a registered two's-complement overflow output (ovf).
module serial_subtractor_nbit #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         b_in,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         b_out
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    ,
    output logic         ovf
`endif
);

    // The counter must be able to hold the value N without wrapping.
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [N-1:0]  a_sr;
    logic [N-1:0]  b_sr;
    logic [N-1:0]  res_sr;
    logic [N-1:0]  res_next;
    logic [CW-1:0] cnt;
    logic          r;
    logic          r_next;
    logic          d;
    logic          a0;
    logic          b0;
    logic          last_step;
    logic          accept;

    // Single full-subtractor cell operating on the current LSBs.
    always_comb begin
        a0        = a_sr[0];
        b0        = b_sr[0];
        d         = a0 ^ b0 ^ r;
        r_next    = (~a0 & b0) | (~(a0 ^ b0) & r);
        res_next  = res_sr >> 1;
        res_next[N-1] = d;
        last_step = (cnt == LAST_CNT);
        accept    = (state != SHIFT) && start;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last_step) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = start ? SHIFT : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Results load only on the final step, so diff/b_out survive a new start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            r      <= 1'b0;
            diff   <= '0;
            b_out  <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            ovf    <= 1'b0;
`endif
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            res_sr <= '0;
            cnt    <= '0;
            r      <= b_in;
        end else if (state == SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= res_next;
            r      <= r_next;
            cnt    <= cnt + CW'(1);
            if (last_step) begin
                diff  <= res_next;
                b_out <= r_next;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
                // Borrow into the MSB step versus borrow out of it.
                ovf   <= r ^ r_next;
`endif
            end
        end
    end

endmodule

// File: doc/serial_subtractor_nbit.md
Name: serial_subtractor_nbit

Overview:
- Bit-serial N-bit subtractor. It computes diff = a - b - b_in one bit per clock, LSB first, using a single full-subtractor cell and a borrow flip-flop.
- It is the area-minimal counterpart to the parallel combinational adder datapath. It is used where operands arrive infrequently and gate count matters more than latency.
- A start/busy/done handshake frames each operation.

Parameters:
- N, 8, operand and result width in bits; legal range N >= 1.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only when busy=0
- a  input  N  minuend; captured on the accepted start
- b  input  N  subtrahend; captured on the accepted start
- b_in  input  1  borrow-in; captured on the accepted start
- busy  output  1  high while bit steps are in progress
- done  output  1  one-cycle pulse when diff and b_out update
- diff  output  N  result a - b - b_in, modulo 2^N
- b_out  output  1  borrow-out from the MSB (1 when a < b + b_in, unsigned)

Behaviour:
Reset:
- One clock (clk); reset is asynchronous and active-low (rst_n). Assertion takes effect immediately, regardless of clk.
- Reset values: busy=0, done=0, diff=0, b_out=0. State=IDLE, counter=0, borrow flop=0, shift registers=0.

States:
- IDLE: busy=0. On a clock edge with start=1, capture a and b into shift registers and b_in into the borrow flop, clear the counter, and go to SHIFT.
- SHIFT: busy=1. Each edge processes the current LSBs a0, b0 and borrow r:
  - d = a0 ^ b0 ^ r
  - r_next = (~a0 & b0) | (~(a0 ^ b0) & r)
  - d shifts into the result register from the MSB end; the a and b shift registers shift right; the counter increments.
  - On the edge that completes step N, load diff from the result register and b_out from r_next, then go to DONE.
- DONE: busy=0, done=1 for exactly this one cycle. The next edge goes to IDLE, or straight to SHIFT if start=1, which captures new operands.

Timing:
- If start is accepted at edge k, busy is high for cycles k+1 .. k+N.
- done is high in the cycle after edge k+N.
- Latency from the start edge to done is N cycles. Maximum throughput is one operation per N+1 cycles.

Output holding:
- diff and b_out change only on the edge that raises done. They hold until the next completion or reset.
- They are not cleared by a new start.

Boundary conditions:
- start=1 while busy=1 is ignored. Operand inputs are don't-care while busy.
- start held high continuously gives back-to-back operations, each re-capturing a, b and b_in on its accept edge.
- If rst_n falls mid-SHIFT, the operation is abandoned: outputs return to reset values and no done pulse is issued.
- Counter width is clog2(N+1), so the counter reaches N without wrap.
- N=1: a single SHIFT cycle, then DONE.
- Arithmetic is unsigned modulo 2^N. Wrap-around appears in diff, with b_out=1.

Optional Feature:
- Macro: SERIAL_SUB_SIGNED_OVF_EN
- Defined: adds output ovf (1 bit, reset 0).
  - ovf = borrow into the MSB step XOR borrow out of the MSB step, which is two's-complement overflow.
  - It is registered at the final step, updates with diff on the done edge, and holds until the next completion.
- Undefined: the ovf port and its flop are absent. All other behaviour is identical.

Test Plan:
- Basic subtraction, N=8: a=100, b=37, b_in=0, start for 1 cycle -> busy high 8 cycles; then done=1 for 1 cycle; diff=63, b_out=0.
- Underflow: a=0x10, b=0x20, b_in=0 -> diff=0xF0, b_out=1. Then a=0x00, b=0x00, b_in=1 -> diff=0xFF, b_out=1.
- Equal operands: a=0xFF, b=0xFF, b_in=0 -> diff=0x00, b_out=0. diff is unchanged between done pulses and after start=0.
- Start held high for 30 cycles with operands changed mid-busy:
  - Only operands present on each accept edge are used.
  - Accepts are every 9 cycles; done pulses at start+8, +17, +26.
  - Mid-busy operand changes have no effect.
- Reset mid-operation: rst_n low at the 4th SHIFT cycle -> busy, done, diff and b_out are 0 immediately. No done pulse follows. The next start computes 5-3 = 2 correctly.
- With SERIAL_SUB_SIGNED_OVF_EN:
  - a=0x80, b=0x01 -> diff=0x7F, ovf=1, b_out=0.
  - a=0x05, b=0x03 -> diff=0x02, ovf=0.
  - Rebuilding without the macro passes the first five scenarios unchanged.
